// File: rtl/upsampler_nx_if.sv
`default_nettype none
// ============================================================================
//  Module      : upsampler_nx_if
//  Description : Bundle of the upsampler's FIFO-side and output-side signals.
//                master : seen by the upsampler. It receives valid/data and
//                         drives fifo_read and the upsampled pixel stream.
//                slave  : seen by the environment, with every direction
//                         reversed.
//  Signals     : valid, data          - FIFO not-empty flag and head pixel
//                fifo_read            - pop strobe, same cycle as consumption
//                dataout, validout    - upsampled pixel and its qualifier
//                current_rowcount/col - scan position counters
//                stall                - scan held waiting for FIFO data
//                sof, eol             - frame/line markers, present only
//                                       when UPSAMPLER_NX_SYNC_FLAGS_EN is
//                                       defined
//  Revision    : 1.0 - initial release
// ============================================================================
interface upsampler_nx_if #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 10
);
    logic              valid;
    logic [DATA_W-1:0] data;
    logic              fifo_read;
    logic [DATA_W-1:0] dataout;
    logic              validout;
    logic [CNT_W-1:0]  current_rowcount;
    logic [CNT_W-1:0]  current_colcount;
    logic              stall;
`ifdef UPSAMPLER_NX_SYNC_FLAGS_EN
    logic              sof;
    logic              eol;
`endif

    modport master (
        input  valid,
        input  data,
`ifdef UPSAMPLER_NX_SYNC_FLAGS_EN
        output sof,
        output eol,
`endif
        output fifo_read,
        output dataout,
        output validout,
        output current_rowcount,
        output current_colcount,
        output stall
    );

    modport slave (
        output valid,
        output data,
`ifdef UPSAMPLER_NX_SYNC_FLAGS_EN
        input  sof,
        input  eol,
`endif
        input  fifo_read,
        input  dataout,
        input  validout,
        input  current_rowcount,
        input  current_colcount,
        input  stall
    );
endinterface
`default_nettype wire

// File: rtl/upsampler_nx.sv
`default_nettype none
// ============================================================================
//  Module      : upsampler_nx
//  Description : Integer-factor nearest-neighbour upsampler. Every source
//                pixel is repeated SCALE times along a row and every source
//                row SCALE times down the frame, inside a raster scan of
//                H_TOTAL x V_TOTAL positions of which OUT_W x OUT_H are
//                active. Source pixels are popped from an external FIFO on
//                the first row of each SCALE-row group and stored in an
//                internal line buffer, which supplies the repeated rows.
//                The scan only ever waits at a fetch position whose FIFO is
//                empty; such waits are reported on stall.
//  Ports       : clock - system clock, rising edge
//                reset - asynchronous, active-high
//                bus   - upsampler_nx_if.master (FIFO side + pixel output)
//  Options     : UPSAMPLER_NX_SYNC_FLAGS_EN - adds sof/eol markers aligned
//                with dataout.
//  Revision    : 1.0 - initial release
// ============================================================================
module upsampler_nx #(
    parameter int DATA_W  = 8,
    parameter int SCALE   = 2,
    parameter int OUT_W   = 800,
    parameter int OUT_H   = 600,
    parameter int H_TOTAL = 841,
    parameter int V_TOTAL = 641,
    parameter int CNT_W   = 10
) (
    input  logic           clock,
    input  logic           reset,
    upsampler_nx_if.master bus
);

    // ------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------
    localparam int               c_LB_DEPTH  = OUT_W / SCALE;
    localparam int               c_LB_AW     = (c_LB_DEPTH > 1) ? $clog2(c_LB_DEPTH) : 1;
    localparam logic [CNT_W-1:0] c_COL_LAST  = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_ROW_LAST  = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_ACT_W     = CNT_W'(OUT_W);
    localparam logic [CNT_W-1:0] c_ACT_H     = CNT_W'(OUT_H);
    localparam logic [CNT_W-1:0] c_CNT_ONE   = CNT_W'(1);
    localparam logic [c_LB_AW-1:0] c_SRC_ONE = c_LB_AW'(1);
    // Phase counters run 0..SCALE-1; SCALE is at most 4, so two bits.
    localparam logic [1:0]       c_PH_LAST   = 2'(SCALE - 1);
`ifdef UPSAMPLER_NX_SYNC_FLAGS_EN
    localparam logic [CNT_W-1:0] c_EOL_COL   = CNT_W'(OUT_W - 1);
`endif

    // ------------------------------------------------------------------
    // Scan position. Alongside row/col we keep the position within the
    // current SCALE group (r_row_ph, r_col_ph) and the source column
    // (r_src_col = col / SCALE), so no divider or modulo is needed.
    // r_src_col keeps counting through horizontal blanking; it is only
    // used inside the active region, where it stays below c_LB_DEPTH.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]   r_row;
    logic [CNT_W-1:0]   r_col;
    logic [1:0]         r_row_ph;
    logic [1:0]         r_col_ph;
    logic [c_LB_AW-1:0] r_src_col;

    logic w_active;
    logic w_fetch;
    logic w_pop;
    logic w_hold;
    logic w_lb_row;

    assign w_active = (r_row < c_ACT_H) && (r_col < c_ACT_W);
    assign w_fetch  = w_active && (r_row_ph == 2'd0) && (r_col_ph == 2'd0);
    // The scan sits at (0,0), a fetch position, throughout reset; gating
    // the pop with reset keeps a pixel from being consumed and lost there.
    assign w_pop    = w_fetch && bus.valid && !reset;
    // The only reason the scan ever waits: a fetch with an empty FIFO.
    assign w_hold   = w_fetch && !bus.valid;
    // Rows after the first of each group replay the line buffer.
    assign w_lb_row = (r_row_ph != 2'd0);

    assign bus.fifo_read = w_pop;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_row     <= '0;
            r_col     <= '0;
            r_row_ph  <= '0;
            r_col_ph  <= '0;
            r_src_col <= '0;
        end else if (!w_hold) begin
            if (r_col == c_COL_LAST) begin
                r_col     <= '0;
                r_col_ph  <= '0;
                r_src_col <= '0;
                if (r_row == c_ROW_LAST) begin
                    r_row    <= '0;
                    r_row_ph <= '0;
                end else begin
                    r_row    <= r_row + c_CNT_ONE;
                    r_row_ph <= (r_row_ph == c_PH_LAST) ? 2'd0 : r_row_ph + 2'd1;
                end
            end else begin
                r_col <= r_col + c_CNT_ONE;
                if (r_col_ph == c_PH_LAST) begin
                    r_col_ph  <= '0;
                    r_src_col <= r_src_col + c_SRC_ONE;
                end else begin
                    r_col_ph <= r_col_ph + 2'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Line buffer: one entry per source column. Contents survive reset;
    // a fresh frame always rewrites an entry on its first row group before
    // any replay row reads it, so stale data is never emitted.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_lb_mem [0:c_LB_DEPTH-1];

    always_ff @(posedge clock) begin
        if (w_pop) begin
            r_lb_mem[r_src_col] <= bus.data;
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: line-buffer read data, hold pixel and position qualifiers.
    // The hold pixel is the most recent pop; non-fetch columns of a fetch
    // row repeat it.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_lb_rd;
    logic [DATA_W-1:0] r_hold_px;
    logic              r_s1_valid;
    logic              r_s1_lb;
    logic              r_stall;
`ifdef UPSAMPLER_NX_SYNC_FLAGS_EN
    logic              r_s1_sof;
    logic              r_s1_eol;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_lb_rd    <= '0;
            r_hold_px  <= '0;
            r_s1_valid <= 1'b0;
            r_s1_lb    <= 1'b0;
            r_stall    <= 1'b0;
        end else begin
            if (w_active && w_lb_row) begin
                r_lb_rd <= r_lb_mem[r_src_col];
            end
            if (w_pop) begin
                r_hold_px <= bus.data;
            end
            // Held cycles produce no output pixel.
            r_s1_valid <= w_active && !w_hold;
            r_s1_lb    <= w_lb_row;
            r_stall    <= w_hold;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: registered outputs, two cycles after the scan position.
    // dataout is forced to zero whenever validout is low.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] r_dataout;
    logic              r_validout;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_dataout  <= '0;
            r_validout <= 1'b0;
        end else begin
            r_validout <= r_s1_valid;
            if (r_s1_valid) begin
                r_dataout <= r_s1_lb ? r_lb_rd : r_hold_px;
            end else begin
                r_dataout <= '0;
            end
        end
    end

    assign bus.dataout          = r_dataout;
    assign bus.validout         = r_validout;
    assign bus.current_rowcount = r_row;
    assign bus.current_colcount = r_col;
    assign bus.stall            = r_stall;

`ifdef UPSAMPLER_NX_SYNC_FLAGS_EN
    // ------------------------------------------------------------------
    // Frame/line markers, pipelined in step with the pixel so they land
    // on the same cycle as the pixel they describe.
    // ------------------------------------------------------------------
    logic r_sof;
    logic r_eol;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_s1_sof <= 1'b0;
            r_s1_eol <= 1'b0;
            r_sof    <= 1'b0;
            r_eol    <= 1'b0;
        end else begin
            r_s1_sof <= !w_hold && (r_row == '0) && (r_col == '0);
            r_s1_eol <= w_active && !w_hold && (r_col == c_EOL_COL);
            r_sof    <= r_s1_sof;
            r_eol    <= r_s1_eol;
        end
    end

    assign bus.sof = r_sof;
    assign bus.eol = r_eol;
`endif

endmodule
`default_nettype wire

// File: doc/upsampler_nx.md
Name: upsampler_nx

Overview:
- Parametrised integer-factor nearest-neighbour upsampler.
- Each source pixel is replicated SCALE times horizontally and each source row SCALE times vertically, inside a raster scan with blanking.
- Sits between an external pixel FIFO, which it pops via fifo_read, and downstream feature-detection stages.
- Holds its own line buffer. Generalises the fixed 2x, 8-bit, 800x600 upsampler to any factor, width and geometry, and adds stall reporting.

Parameters:
- DATA_W, 8: pixel width in bits.
- SCALE, 2: integer upsampling factor, 1 to 4.
- OUT_W, 800: active output columns; must be a multiple of SCALE.
- OUT_H, 600: active output rows; must be a multiple of SCALE.
- H_TOTAL, 841: columns per scan line including blanking; must exceed OUT_W.
- V_TOTAL, 641: rows per frame including blanking; must exceed OUT_H.
- CNT_W, 10: width of the row and column counters; must hold H_TOTAL-1 and V_TOTAL-1.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- valid  in  1  FIFO has a pixel (not empty).
- data  in  DATA_W  FIFO head pixel.
- fifo_read  out  1  pop strobe; combinational, same cycle as consumption.
- dataout  out  DATA_W  upsampled pixel.
- validout  out  1  dataout is an active output pixel.
- current_rowcount  out  CNT_W  scan row counter.
- current_colcount  out  CNT_W  scan column counter.
- stall  out  1  registered; high when the scan is held waiting for FIFO data.

Behaviour:
- Reset:
  - Asserting reset clears all registers immediately, whatever the operation in progress: counters, pipeline, hold pixel, dataout, validout, stall, and the optional flags.
  - Line-buffer RAM contents are not reset.
  - First cycle after reset release: scan position is (row 0, col 0).
- Active region: row < OUT_H and col < OUT_W.
- Fetch position: active, row % SCALE == 0 and col % SCALE == 0.
- fifo_read = fetch position AND valid. It is never asserted outside a fetch position.
- Counter advance:
  - At a fetch position with valid = 0 the counters hold. That is the only hold condition; every other cycle they advance, including blanking.
  - Column wraps from H_TOTAL-1 to 0 and increments the row.
  - Row wraps from V_TOTAL-1 to 0 on the same column-wrap cycle.
  - No off-by-one extra columns.
- Source pixel by row phase:
  - row % SCALE == 0: the pixel popped at a fetch is written to line buffer address col/SCALE and captured in a hold register. Non-fetch columns reuse the hold register.
  - row % SCALE != 0: the pixel is read from line-buffer address col/SCALE.
  - Synchronous-read RAM, depth OUT_W/SCALE.
- Output latency:
  - Two cycles from a scan position to its dataout/validout.
  - A pixel popped in cycle t appears on dataout at t+2.
- validout:
  - High two cycles after every advancing active position.
  - Low for blanking and for held (stalled) cycles.
  - dataout is 0 whenever validout is 0.
- stall: registered, high during cycles where the scan holds. stall = 1 coincides with validout = 0 two cycles later.
- Simultaneous events: a pop on the last fetch of a row, followed by the wrap, needs no special case; the counters advance normally.
- FIFO underflow is impossible by construction; there is no overflow path.

Optional Feature:
- Macro: UPSAMPLER_NX_SYNC_FLAGS_EN.
- Defined: adds outputs sof and eol, each 1 bit, registered and aligned with dataout.
  - sof is high with the pixel at (0,0).
  - eol is high with the pixel at col OUT_W-1 of each active row.
  - Both reset to 0.
- Undefined: the ports do not exist, and no logic is generated for them.

Test Plan:
- Test config: SCALE=2, OUT_W=8, OUT_H=4, H_TOTAL=10, V_TOTAL=6.
1. Constant valid, FIFO ramp 1,2,3,...:
   - Out rows 0/1: 1,1,2,2,3,3,4,4. Out rows 2/3: 5,5,6,6,7,7,8,8.
   - 8 fifo_read pulses per frame.
   - 60 cycles between successive (0,0) positions.
2. valid dropped for 3 cycles at fetch (row 0, col 2):
   - Counters hold at col 2; stall high for 3 cycles.
   - validout gap of 3 cycles; pixel sequence identical to scenario 1.
3. valid low throughout blanking and in line-buffer rows 1/3:
   - No stall, no fifo_read, and rows 1/3 output matches rows 0/2.
4. Reset asserted asynchronously at (row 1, col 5):
   - All outputs are 0 immediately.
   - After release, the next frame starts at (0,0) with fresh fetches; the stale line buffer is never emitted.
5. Reparametrise SCALE=3, OUT_W=9, OUT_H=6, H_TOTAL=12, V_TOTAL=8, FIFO values 10,20,30,...:
   - Out rows 0..2: 10,10,10,20,20,20,30,30,30.
   - 6 pops per frame.
6. With UPSAMPLER_NX_SYNC_FLAGS_EN, config of scenario 1:
   - sof is a single pulse alongside the first 1.
   - eol pulses alongside the 8th pixel of each of the 4 rows.
